// File: rtl/robot_pkg.sv
// Shared definitions for the robot code-entry sender and checker.
// Status encodings, default flush digit and sender state encoding.
package robot_pkg;

  localparam logic [1:0] ST_ERR  = 2'b00;
  localparam logic [1:0] ST_PART = 2'b01;
  localparam logic [1:0] ST_OK   = 2'b11;
  localparam logic [1:0] ST_PROC = 2'b10;

  localparam logic [3:0] FLUSH_DIGIT_DEF = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_GAPW   = 2'd2,
    S_FINISH = 2'd3
  } sender_state_t;

endpackage

// File: rtl/robot_code_sender_if.sv
// Host request/verdict signals plus the checker insere/entrada/status link.
// Master is the sender; slave is whatever submits codes and models the checker.
interface robot_code_sender_if #(
  parameter int N_DIGITS = 5,
  parameter int DIGIT_W  = 4
);

  logic                          start;
  logic [N_DIGITS*DIGIT_W-1:0]   code;
`ifdef SENDER_ERR_INJECT_EN
  logic [N_DIGITS-1:0]           err_mask;
`endif
  logic [1:0]                    status_in;
  logic                          insere;
  logic [DIGIT_W-1:0]            entrada;
  logic                          busy;
  logic                          done;
  logic [1:0]                    result;
  logic                          timeout;

`ifdef SENDER_ERR_INJECT_EN
  modport master (
    input  start, code, err_mask, status_in,
    output insere, entrada, busy, done, result, timeout
  );
  modport slave (
    output start, code, err_mask, status_in,
    input  insere, entrada, busy, done, result, timeout
  );
`else
  modport master (
    input  start, code, status_in,
    output insere, entrada, busy, done, result, timeout
  );
  modport slave (
    output start, code, status_in,
    input  insere, entrada, busy, done, result, timeout
  );
`endif

endinterface

// File: rtl/robot_strobe_timer.sv
// GAP down-counter: reloads on the strobe cycle, ticks sample on the first gap
// cycle and strobe-enable on the last one. No backpressure; purely time-driven.
module robot_strobe_timer #(
  parameter int GAP = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic sample_tick,
  output logic strobe_tick
);

  localparam int CNT_W = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] GAP_V = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (load) begin
      cnt_d = GAP_V;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE_V;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With GAP=1 both ticks land on the single gap cycle.
  assign sample_tick = run && (cnt_q == GAP_V);
  assign strobe_tick = run && (cnt_q == ONE_V);

endmodule

// File: rtl/robot_code_sender.sv
// Sends an N-digit code as insere/entrada strobes, flushes until the checker leaves processo, reports done.
// First strobe 1 cycle after start; start ignored while busy. Optional err_mask via SENDER_ERR_INJECT_EN.
module robot_code_sender
  import robot_pkg::*;
#(
  parameter int                 N_DIGITS    = 5,
  parameter int                 DIGIT_W     = 4,
  parameter int                 GAP         = 2,
  parameter int                 MAX_FLUSH   = 4,
  parameter logic [DIGIT_W-1:0] FLUSH_DIGIT = DIGIT_W'(FLUSH_DIGIT_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  robot_code_sender_if.master bus
);

  localparam int K_W = $clog2(N_DIGITS + 1);
  localparam int F_W = $clog2(MAX_FLUSH + 1);
  localparam logic [K_W-1:0] K_END = K_W'(N_DIGITS);
  localparam logic [F_W-1:0] F_END = F_W'(MAX_FLUSH);
  localparam logic [K_W-1:0] K_ONE = K_W'(1);
  localparam logic [F_W-1:0] F_ONE = F_W'(1);

  sender_state_t               state_q, state_d;
  logic [N_DIGITS*DIGIT_W-1:0] code_q, code_d;
  logic [K_W-1:0]              k_q, k_d;
  logic [F_W-1:0]              f_q, f_d;
  logic [1:0]                  result_q, result_d;
  logic                        timeout_q, timeout_d;
`ifdef SENDER_ERR_INJECT_EN
  logic [N_DIGITS-1:0]         mask_q, mask_d;
`endif

  logic                        is_digit;
  logic                        flip;
  logic [DIGIT_W-1:0]          digit_raw;
  logic [DIGIT_W-1:0]          digit_tx;
  logic                        sample_tick;
  logic                        strobe_tick;

  robot_strobe_timer #(
    .GAP (GAP)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .load        (state_q == S_STROBE),
    .run         (state_q == S_GAPW),
    .sample_tick (sample_tick),
    .strobe_tick (strobe_tick)
  );

  assign is_digit = (k_q < K_END);

  always_comb begin
    digit_raw = '0;
    flip      = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (k_q == K_W'(i)) begin
        digit_raw = code_q[i*DIGIT_W +: DIGIT_W];
`ifdef SENDER_ERR_INJECT_EN
        flip      = mask_q[i];
`endif
      end
    end
    digit_tx = flip ? ~digit_raw : digit_raw;
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    k_d       = k_q;
    f_d       = f_q;
    result_d  = result_q;
    timeout_d = timeout_q;
`ifdef SENDER_ERR_INJECT_EN
    mask_d    = mask_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_STROBE;
          code_d    = bus.code;
          k_d       = '0;
          f_d       = '0;
          timeout_d = 1'b0;
`ifdef SENDER_ERR_INJECT_EN
          mask_d    = bus.err_mask;
`endif
        end
      end
      S_STROBE: begin
        state_d = S_GAPW;
        if (is_digit) begin
          k_d = k_q + K_ONE;
        end else begin
          f_d = f_q + F_ONE;
        end
      end
      S_GAPW: begin
        // The checker registers on the strobe edge, so its answer is valid here.
        if (sample_tick && (bus.status_in != ST_PROC)) begin
          result_d = bus.status_in;
          state_d  = S_FINISH;
        end else if (sample_tick && (k_q == K_END) && (f_q == F_END)) begin
          result_d  = ST_PROC;
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else if (strobe_tick) begin
          state_d = S_STROBE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      k_q       <= '0;
      f_q       <= '0;
      result_q  <= ST_PROC;
      timeout_q <= 1'b0;
`ifdef SENDER_ERR_INJECT_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      k_q       <= k_d;
      f_q       <= f_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
`ifdef SENDER_ERR_INJECT_EN
      mask_q    <= mask_d;
`endif
    end
  end

  assign bus.insere  = (state_q == S_STROBE);
  assign bus.entrada = (state_q != S_STROBE) ? '0 :
                       (is_digit ? digit_tx : FLUSH_DIGIT);
  assign bus.busy    = (state_q == S_STROBE) || (state_q == S_GAPW);
  assign bus.done    = (state_q == S_FINISH);
  assign bus.result  = result_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_robot_code_sender.sv
// Directed bench for robot_code_sender with a small checker model (secret 1,8,5,2,3).
// Status can be forced to a fixed value to reach timeout and parcial paths.
module tb_robot_code_sender;
  import robot_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  robot_code_sender_if #(.N_DIGITS(5), .DIGIT_W(4)) ifc ();

  robot_code_sender dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Checker model: a wrong digit is reported after the 5th digit,
  // a correct code needs one more strobe to confirm.
  logic [3:0] secret [5] = '{4'd1, 4'd8, 4'd5, 4'd2, 4'd3};
  logic [1:0] chk_st  = ST_PROC;
  int         chk_idx = 0;
  logic       chk_err = 1'b0;
  logic       chk_clr = 1'b1;
  logic       force_en = 1'b0;
  logic [1:0] force_val = ST_PROC;

  always @(posedge clk) begin
    logic bad;
    if (chk_clr) begin
      chk_st  <= ST_PROC;
      chk_idx <= 0;
      chk_err <= 1'b0;
    end else if (ifc.insere && chk_st == ST_PROC) begin
      if (chk_idx < 5) begin
        bad = (ifc.entrada != secret[chk_idx]);
        chk_idx <= chk_idx + 1;
        chk_err <= chk_err | bad;
        if (chk_idx == 4 && (chk_err || bad)) chk_st <= ST_ERR;
      end else begin
        chk_st <= ST_OK;
      end
    end
  end

  assign ifc.status_in = force_en ? force_val : chk_st;

  logic [3:0] st_ent[$];
  int         st_cyc[$];
  int         n_done   = 0;
  int         idle_bad = 0;

  always @(negedge clk) begin
    if (ifc.insere === 1'b1) begin
      st_ent.push_back(ifc.entrada);
      st_cyc.push_back(cyc);
    end else if (ifc.entrada !== '0) begin
      idle_bad++;
    end
    if (ifc.done === 1'b1) n_done++;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int c0     = 0;
  int dcyc   = 0;
  int d1     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_start(input logic [19:0] c);
    @(negedge clk);
    chk_clr = 1'b1;
    st_ent.delete();
    st_cyc.delete();
    @(negedge clk);
    chk_clr   = 1'b0;
    ifc.code  = c;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    c0 = cyc;
    check("first_strobe", ifc.insere, 1);
    check("first_digit", ifc.entrada, c[3:0]);
    check("busy_on", ifc.busy, 1);
  endtask

  task automatic wait_done(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) begin
        hit  = 1'b1;
        dcyc = cyc;
        check("busy_off_at_done", ifc.busy, 0);
      end
    end
    #1;
    check("done_seen", hit, 1);
  endtask

  initial begin
    logic [19:0] sent;
    int s;
    reset     = 1'b0;
    ifc.start = 1'b0;
    ifc.code  = '0;
`ifdef SENDER_ERR_INJECT_EN
    ifc.err_mask = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_insere", ifc.insere, 0);
    check("rst_entrada", ifc.entrada, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_result", ifc.result, ST_PROC);
    check("rst_timeout", ifc.timeout, 0);
    reset = 1'b1;

    // Success path: 5 digits + one flush, done 17 cycles after first strobe.
    run_start(20'h32581);
    wait_done(60);
    check("ok_nstrobe", st_cyc.size(), 6);
    sent = {st_ent[4], st_ent[3], st_ent[2], st_ent[1], st_ent[0]};
    check("ok_digits", sent, 20'h32581);
    check("ok_cad4", st_cyc[4] - c0, 12);
    check("ok_flush_t", st_cyc[5] - c0, 15);
    check("ok_flush_d", st_ent[5], 4'hF);
    check("ok_done_t", dcyc - c0, 17);
    check("ok_result", ifc.result, ST_OK);
    check("ok_timeout", ifc.timeout, 0);

    // Wrong digit: verdict after digit 4, no flush.
    run_start(20'h32591);
    wait_done(60);
    check("err_nstrobe", st_cyc.size(), 5);
    check("err_done_t", dcyc - c0, 14);
    check("err_result", ifc.result, ST_ERR);

    // Parcial forced right away: single strobe, early finish.
    force_en  = 1'b1;
    force_val = ST_PART;
    run_start(20'h32581);
    wait_done(20);
    check("part_nstrobe", st_cyc.size(), 1);
    check("part_done_t", dcyc - c0, 2);
    check("part_result", ifc.result, ST_PART);

    // Timeout: status stuck at processo.
    force_val = ST_PROC;
    run_start(20'h32581);
    wait_done(80);
    check("to_nstrobe", st_cyc.size(), 9);
    check("to_flush1", st_ent[5], 4'hF);
    check("to_flush4", st_ent[8], 4'hF);
    check("to_last_t", st_cyc[8] - c0, 24);
    check("to_done_t", dcyc - c0, 26);
    check("to_result", ifc.result, ST_PROC);
    check("to_timeout", ifc.timeout, 1);

    // start held high: second transaction only after IDLE.
    force_val = ST_PART;
    @(negedge clk);
    st_ent.delete();
    st_cyc.delete();
    ifc.start = 1'b1;
    wait_done(20);
    d1 = dcyc;
    check("hold_timeout_clr", ifc.timeout, 0);
    check("hold_result", ifc.result, ST_PART);
    @(negedge clk);
    check("hold_idle_gap", ifc.insere, 0);
    @(negedge clk);
    check("hold_restrobe", ifc.insere, 1);
    ifc.start = 1'b0;
    wait_done(20);
    check("hold_done2_t", dcyc - d1, 4);
    repeat (4) @(negedge clk);
    #1;
    check("hold_nstrobe", st_cyc.size(), 2);

    // start pulsed mid-transaction is ignored.
    force_en = 1'b0;
    run_start(20'h32581);
    repeat (4) @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(60);
    check("pulse_done_t", dcyc - c0, 17);
    repeat (4) @(negedge clk);
    #1;
    check("pulse_nstrobe", st_cyc.size(), 6);
    check("pulse_idle", ifc.busy, 0);
    check("pulse_result", ifc.result, ST_OK);

    // Reset during the third strobe.
    run_start(20'h32581);
    s = 1;
    for (int i = 0; i < 20 && s < 3; i++) begin
      @(negedge clk);
      if (ifc.insere === 1'b1) s++;
    end
    check("rst3_reached", s, 3);
    reset = 1'b0;
    @(negedge clk);
    check("rst3_insere", ifc.insere, 0);
    check("rst3_busy", ifc.busy, 0);
    check("rst3_result", ifc.result, ST_PROC);
    check("rst3_done", ifc.done, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("rst3_nstrobe", st_cyc.size(), 3);
    run_start(20'h32584);
    wait_done(60);
    check("rst3_new_nstrobe", st_cyc.size(), 5);
    check("rst3_new_done_t", dcyc - c0, 14);
    check("rst3_new_result", ifc.result, ST_ERR);

`ifdef SENDER_ERR_INJECT_EN
    ifc.err_mask = 5'b00010;
    run_start(20'h32581);
    wait_done(60);
    check("inj_digit1", st_ent[1], 4'b0111);
    check("inj_digit2", st_ent[2], 4'h5);
    check("inj_result", ifc.result, ST_ERR);
    ifc.err_mask = '0;
    check("inj_ndone", n_done, 9);
`else
    check("ndone", n_done, 8);
`endif
    check("entrada_idle_zero", idle_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/robot_code_sender.md
Name: robot_code_sender

Overview:
Initiator side of the robot code-entry interface. It takes an N-digit code and drives the digit checker's `insere`/`entrada` strobe protocol, one digit per strobe at a fixed cadence. It then issues flush strobes until the checker's 2-bit status leaves "processo". The block captures the final status and reports `done`, so a test controller or CPU can submit codes and read verdicts without cycle-level handling.

Parameters:
- N_DIGITS, 5: digits per code.
- DIGIT_W, 4: bits per digit.
- GAP, 2: idle cycles between strobes. Must be at least 1.
- MAX_FLUSH, 4: flush strobes sent after the last digit before declaring timeout.
- FLUSH_DIGIT, 4'hF: value driven on `entrada` during flush strobes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset. 0 = reset, sampled on the clk rising edge.
- start  in  1  request to send `code`. Sampled only in IDLE.
- code  in  N_DIGITS*DIGIT_W  packed code. Digit 0 is in the LSBs and is sent first. Latched on an accepted start.
- status_in  in  2  checker status: 00 errado, 01 parcial, 11 sucesso, 10 processo.
- insere  out  1  one-cycle entry strobe to the checker.
- entrada  out  DIGIT_W  digit presented with `insere`.
- busy  out  1  high from the cycle after start is accepted until `done`.
- done  out  1  one-cycle pulse when a verdict or timeout is final.
- result  out  2  captured status. Held until the next accepted start.
- timeout  out  1  set with `done` if MAX_FLUSH flushes elapse while status is still 10.

Behaviour:
- Reset values (reset=0): insere=0, entrada=0, busy=0, done=0, result=2'b10, timeout=0, state=IDLE, all counters 0.
- States:
  - IDLE: wait for start.
  - STROBE: insere=1 for exactly 1 cycle.
  - GAPW: GAP cycles with insere=0.
  - FINISH: done=1 for 1 cycle, then back to IDLE.
- Start accepted in IDLE at edge T:
  - `code` latched, digit index k=0, flush count f=0, timeout cleared, busy=1.
  - First strobe is visible in the cycle after T.
- Cadence: digit k strobes in cycle T+1+k*(GAP+1). Flush strobes continue at the same cadence.
- `entrada` is driven only during a strobe and returns to 0 otherwise.
- Status sampling: `status_in` is sampled at the edge ending the first GAPW cycle after each strobe, because the checker registers its status on the strobe edge.
  - If the sampled status is not 10, `result` is set to it, the state goes to FINISH, and remaining digits and flushes are skipped (early termination).
- After digit N_DIGITS-1: if status is still 10, send flush strobes with entrada=FLUSH_DIGIT, incrementing f after each.
- Timeout: if f reaches MAX_FLUSH and the status sampled after that flush is still 10, then result=2'b10, timeout=1, and go to FINISH.
- done: asserted the cycle after the deciding sample. busy falls in the same cycle done rises.
- start while not IDLE is ignored, including in the FINISH cycle.
- reset=0 mid-operation: back to IDLE in the next cycle. No strobe is issued after that reset edge, and `result` returns to 10.
- Width rules: k counter is ceil(log2(N_DIGITS+1)) bits, f counter is ceil(log2(MAX_FLUSH+1)) bits, gap counter is ceil(log2(GAP+1)) bits. None of them wrap during a transaction.

Optional Feature:
- Macro: SENDER_ERR_INJECT_EN.
- When defined:
  - Adds input err_mask[N_DIGITS-1:0], latched with `code`.
  - Digit k is sent bitwise inverted when err_mask[k]=1.
  - Used to exercise the checker's parcial and errado paths.
- When undefined: the port is absent and digits are always sent unmodified.

Decomposition:
- Package robot_pkg holds:
  - status constants ST_ERR=2'b00, ST_PART=2'b01, ST_OK=2'b11, ST_PROC=2'b10;
  - FLUSH_DIGIT default;
  - sender state encoding.
- The checker and this sender both import the package.
- One sub-module, robot_strobe_timer: a GAP down-counter that produces the strobe-enable and sample-enable ticks.

Test Plan:
1. Success path, GAP=2, against the checker model:
   - Stimulus: code 1,8,5,2,3.
   - Strobes at T+1, T+4, T+7, T+10, T+13, with the status after the last digit still 10.
   - One flush at T+16.
   - Expected: result=11, timeout=0, done pulse at T+18.
2. Wrong digits: code 1,9,5,2,3 → status 00 sampled after digit 4; no flush strobe; result=00, done=1.
3. Timeout: status_in tied to 10, MAX_FLUSH=4 → exactly 5 digit strobes and 4 flush strobes with entrada=F; result=10, timeout=1.
4. Protocol edges:
   - start held high continuously: exactly one transaction runs, and the next is accepted only in IDLE after done.
   - start pulsed during busy: ignored.
5. Reset=0 asserted in the cycle of the third strobe → insere=0 from the next cycle; busy=0, result=10, state IDLE. A new start then sends from digit 0.
6. SENDER_ERR_INJECT_EN with err_mask=5'b00010 on code 1,8,5,2,3 → second strobe carries entrada=4'b0111; result matches the checker model verdict.
